// File: rtl/axi_error_slave_if.sv
// AXI4 channel bundle shared by masters and slaves; widths are set here.
interface axi_channel #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  // write address channel
  logic              aw_valid;
  logic              aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic [USER_W-1:0] aw_user;
  // write data channel
  logic                aw_unused_pad;
  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  // write response channel
  logic              b_valid;
  logic              b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic [USER_W-1:0] b_user;
  // read address channel
  logic              ar_valid;
  logic              ar_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [USER_W-1:0] ar_user;
  // read data channel
  logic              r_valid;
  logic              r_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [USER_W-1:0] r_user;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );
endinterface

// File: rtl/axi_error_slave.sv
// Terminating AXI4 slave: every write and read completes with an error response.
// Write and read paths are independent FSMs, one outstanding transaction each.
module axi_error_slave #(
  parameter logic [1:0] RESP = 2'b11
) (
  input logic        clk,
  input logic        rst,
  axi_channel.slave  master
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic [$bits(master.aw_id)-1:0] w_id_reg;
  logic [$bits(master.ar_id)-1:0] r_id_reg;
  logic [7:0]                     cnt_reg;

  // Response payload never varies; data and user fields are tied off.
  assign master.b_resp = RESP;
  assign master.r_resp = RESP;
  assign master.b_user = '0;
  assign master.r_user = '0;
  assign master.r_data = '0;
  assign master.b_id   = w_id_reg;
  assign master.r_id   = r_id_reg;

  // Write FSM state register and AW ID capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (w_state_reg == W_IDLE && master.aw_valid)
        w_id_reg <= master.aw_id;
    end
  end

  // Write FSM next state and handshake outputs; everything forced low in reset.
  always_comb begin
    w_state_next    = w_state_reg;
    master.aw_ready = 1'b0;
    master.w_ready  = 1'b0;
    master.b_valid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        master.aw_ready = !rst;
        if (master.aw_valid) w_state_next = W_DATA;
      end
      W_DATA: begin
        // aw_len is ignored: only w_last closes the burst.
        master.w_ready = !rst;
        if (master.w_valid && master.w_last) w_state_next = W_RESP;
      end
      W_RESP: begin
        master.b_valid = !rst;
        if (master.b_ready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Read FSM state register, ID capture and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (r_state_reg == R_IDLE && master.ar_valid) begin
        r_id_reg <= master.ar_id;
        cnt_reg  <= master.ar_len;
      end else if (r_state_reg == R_DATA && master.r_ready && cnt_reg != 8'd0) begin
        cnt_reg <= cnt_reg - 8'd1;
      end
    end
  end

  // Read FSM next state and outputs; cnt==0 marks the final beat, so 255 gives 256 beats.
  always_comb begin
    r_state_next    = r_state_reg;
    master.ar_ready = 1'b0;
    master.r_valid  = 1'b0;
    master.r_last   = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        master.ar_ready = !rst;
        if (master.ar_valid) r_state_next = R_DATA;
      end
      R_DATA: begin
        master.r_valid = !rst;
        master.r_last  = !rst && (cnt_reg == 8'd0);
        if (master.r_ready && cnt_reg == 8'd0) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_error_slave.sv
// Directed bench for axi_error_slave: writes, reads, concurrency and mid-burst reset.
module tb_axi_error_slave;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  axi_channel #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .USER_W(1)) bus ();

  axi_error_slave #(.RESP(2'b11)) dut (
    .clk    (clk),
    .rst    (rst),
    .master (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_aw_ready"}, 32'(bus.aw_ready), 32'd0);
    check({tag, "_w_ready"},  32'(bus.w_ready),  32'd0);
    check({tag, "_b_valid"},  32'(bus.b_valid),  32'd0);
    check({tag, "_ar_ready"}, 32'(bus.ar_ready), 32'd0);
    check({tag, "_r_valid"},  32'(bus.r_valid),  32'd0);
    check({tag, "_r_last"},   32'(bus.r_last),   32'd0);
  endtask

  initial begin
    int beats;
    logic pat [6];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0;
    bus.aw_size = 0; bus.aw_burst = 0; bus.aw_user = 0; bus.aw_unused_pad = 0;
    bus.w_valid = 0; bus.w_data = 32'hdeadbeef; bus.w_strb = 4'hf; bus.w_last = 0; bus.w_user = 0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0;
    bus.ar_size = 0; bus.ar_burst = 0; bus.ar_user = 0;
    bus.r_ready = 0;

    // reset state
    tick(); tick();
    check_all_low("rst");
    rst = 1'b0;
    #1;
    check("rst_rel_aw_ready", 32'(bus.aw_ready), 32'd1);
    check("rst_rel_ar_ready", 32'(bus.ar_ready), 32'd1);
    $display("reset released");

    // single write, id 5
    bus.aw_valid = 1; bus.aw_id = 4'd5; bus.aw_len = 0;
    tick();
    bus.aw_valid = 0; bus.w_valid = 1; bus.w_last = 1;
    check("w1_w_ready", 32'(bus.w_ready), 32'd1);
    check("w1_aw_ready", 32'(bus.aw_ready), 32'd0);
    check("w1_b_early", 32'(bus.b_valid), 32'd0);
    tick();
    bus.w_valid = 0; bus.w_last = 0; bus.b_ready = 1;
    check("w1_b_valid", 32'(bus.b_valid), 32'd1);
    check("w1_b_id", 32'(bus.b_id), 32'd5);
    check("w1_b_resp", 32'(bus.b_resp), 32'd3);
    check("w1_b_user", 32'(bus.b_user), 32'd0);
    check("w1_w_ready_resp", 32'(bus.w_ready), 32'd0);
    tick();
    bus.b_ready = 0;
    check("w1_b_done", 32'(bus.b_valid), 32'd0);
    check("w1_aw_back", 32'(bus.aw_ready), 32'd1);
    $display("write id=5 len=0 done");

    // 4-beat write with toggling w_valid, b_ready delayed 3 cycles
    bus.aw_valid = 1; bus.aw_id = 4'd7; bus.aw_len = 8'd3;
    tick();
    bus.aw_valid = 0;
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      bus.w_valid = (i % 2 == 0);
      bus.w_last  = (i == 6);
      #1;
      check("w4_ready", 32'(bus.w_ready), 32'd1);
      check("w4_b_early", 32'(bus.b_valid), 32'd0);
      if (bus.w_valid && bus.w_ready) beats++;
      tick();
    end
    bus.w_valid = 0; bus.w_last = 0;
    check("w4_beats", 32'(beats), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("w4_b_hold_valid", 32'(bus.b_valid), 32'd1);
      check("w4_b_hold_id", 32'(bus.b_id), 32'd7);
      check("w4_b_hold_resp", 32'(bus.b_resp), 32'd3);
      tick();
    end
    bus.b_ready = 1;
    tick();
    bus.b_ready = 0;
    check("w4_b_done", 32'(bus.b_valid), 32'd0);
    check("w4_aw_back", 32'(bus.aw_ready), 32'd1);
    check("w4_w_ready_idle", 32'(bus.w_ready), 32'd0);
    $display("write id=7 4 beats done");

    // read id 3, len 3, r_ready pattern 1,0,0,1,1,1
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1;
    bus.ar_valid = 1; bus.ar_id = 4'd3; bus.ar_len = 8'd3;
    tick();
    bus.ar_valid = 0;
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      bus.r_ready = pat[i];
      #1;
      check("r4_valid", 32'(bus.r_valid), 32'd1);
      check("r4_id", 32'(bus.r_id), 32'd3);
      check("r4_resp", 32'(bus.r_resp), 32'd3);
      check("r4_data", bus.r_data, 32'd0);
      check("r4_last", 32'(bus.r_last), 32'(beats == 3));
      check("r4_ar_ready", 32'(bus.ar_ready), 32'd0);
      if (bus.r_valid && bus.r_ready) beats++;
      tick();
    end
    bus.r_ready = 0;
    check("r4_beats", 32'(beats), 32'd4);
    check("r4_end_valid", 32'(bus.r_valid), 32'd0);
    check("r4_ar_back", 32'(bus.ar_ready), 32'd1);
    $display("read id=3 len=3 done");

    // long read, 256 beats
    bus.ar_valid = 1; bus.ar_id = 4'd9; bus.ar_len = 8'd255;
    tick();
    bus.ar_valid = 0; bus.r_ready = 1;
    for (int i = 0; i < 256; i++) begin
      check("r256_valid", 32'(bus.r_valid), 32'd1);
      check("r256_last", 32'(bus.r_last), 32'(i == 255));
      tick();
    end
    bus.r_ready = 0;
    check("r256_end_valid", 32'(bus.r_valid), 32'd0);
    check("r256_ar_back", 32'(bus.ar_ready), 32'd1);
    $display("read id=9 len=255 done");

    // concurrent AW(id 1, 2 beats) and AR(id 2, len 1); b_ready held low
    bus.aw_valid = 1; bus.aw_id = 4'd1; bus.aw_len = 8'd1;
    bus.ar_valid = 1; bus.ar_id = 4'd2; bus.ar_len = 8'd1;
    #1;
    check("cc_aw_ready", 32'(bus.aw_ready), 32'd1);
    check("cc_ar_ready", 32'(bus.ar_ready), 32'd1);
    tick();
    bus.aw_valid = 0; bus.ar_valid = 0;
    bus.r_ready = 1; bus.b_ready = 0;
    bus.w_valid = 1; bus.w_last = 0;
    check("cc_w_ready", 32'(bus.w_ready), 32'd1);
    check("cc_r0_valid", 32'(bus.r_valid), 32'd1);
    check("cc_r0_id", 32'(bus.r_id), 32'd2);
    check("cc_r0_last", 32'(bus.r_last), 32'd0);
    tick();
    bus.w_last = 1;
    check("cc_r1_valid", 32'(bus.r_valid), 32'd1);
    check("cc_r1_last", 32'(bus.r_last), 32'd1);
    tick();
    bus.w_valid = 0; bus.w_last = 0; bus.r_ready = 0;
    check("cc_r_done", 32'(bus.r_valid), 32'd0);
    check("cc_ar_back", 32'(bus.ar_ready), 32'd1);
    check("cc_b_valid", 32'(bus.b_valid), 32'd1);
    check("cc_b_id", 32'(bus.b_id), 32'd1);
    tick();
    check("cc_b_hold", 32'(bus.b_valid), 32'd1);
    bus.b_ready = 1;
    tick();
    bus.b_ready = 0;
    check("cc_b_done", 32'(bus.b_valid), 32'd0);
    check("cc_aw_back", 32'(bus.aw_ready), 32'd1);
    $display("concurrent write id=1 / read id=2 done");

    // reset after R beat 2 of 8 and W beat 1 of 4
    bus.aw_valid = 1; bus.aw_id = 4'd6; bus.aw_len = 8'd3;
    bus.ar_valid = 1; bus.ar_id = 4'd8; bus.ar_len = 8'd7;
    tick();
    bus.aw_valid = 0; bus.ar_valid = 0;
    bus.r_ready = 1; bus.w_valid = 1; bus.w_last = 0;
    tick();
    bus.w_valid = 0;
    tick();
    check("ab_r_mid", 32'(bus.r_valid), 32'd1);
    rst = 1; bus.r_ready = 0; bus.b_ready = 1;
    #1;
    check_all_low("ab_rst");
    tick();
    check_all_low("ab_rst_edge");
    rst = 0;
    #1;
    check("ab_aw_ready", 32'(bus.aw_ready), 32'd1);
    check("ab_ar_ready", 32'(bus.ar_ready), 32'd1);
    check("ab_w_ready", 32'(bus.w_ready), 32'd0);
    bus.r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("ab_no_r", 32'(bus.r_valid), 32'd0);
      check("ab_no_b", 32'(bus.b_valid), 32'd0);
      tick();
    end
    bus.ar_valid = 1; bus.ar_id = 4'd4; bus.ar_len = 8'd0;
    tick();
    bus.ar_valid = 0;
    check("ab_new_valid", 32'(bus.r_valid), 32'd1);
    check("ab_new_last", 32'(bus.r_last), 32'd1);
    check("ab_new_id", 32'(bus.r_id), 32'd4);
    tick();
    bus.r_ready = 0; bus.b_ready = 0;
    check("ab_new_done", 32'(bus.r_valid), 32'd0);
    check("ab_new_ar_back", 32'(bus.ar_ready), 32'd1);
    $display("reset mid-burst and recovery read id=4 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
